// File: rtl/ui_debounce.sv
// ui_debounce: input conditioning for raw pins.
// Each bit gets a two-flop synchroniser and then a stability filter. The
// filter accepts a new value only after it has held for STABLE consecutive
// synchronised cycles. The outputs are a clean level and one-cycle edge pulses.
//
// Parameters:
//   WIDTH  - number of independent input bits (default 8)
//   STABLE - cycles a new value must persist before acceptance (2..65535)
// Ports:
//   clk    - clock, rising edge
//   rst_n  - asynchronous active-low reset
//   raw    - unsynchronised pin values
//   level  - debounced level per bit (registered)
//   rise   - one-cycle pulse when level[i] goes 0->1 (registered)
//   fall   - one-cycle pulse when level[i] goes 1->0 (registered),
//            present only when UI_DEBOUNCE_FALL_EN is defined
// Configuration macro: UI_DEBOUNCE_FALL_EN
module ui_debounce #(
  parameter int unsigned WIDTH  = 8,
  parameter int unsigned STABLE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise
`ifdef UI_DEBOUNCE_FALL_EN
  ,
  output logic [WIDTH-1:0] fall
`endif
);

  localparam int unsigned CW = $clog2(STABLE);
  localparam logic [CW-1:0] CNT_MAX = CW'(STABLE - 1);

  logic [WIDTH-1:0]         s1;
  logic [WIDTH-1:0]         s2;
  logic [WIDTH-1:0][CW-1:0] cnt;
  logic [WIDTH-1:0][CW-1:0] cnt_next;
  logic [WIDTH-1:0]         level_next;
  logic [WIDTH-1:0]         rise_next;
`ifdef UI_DEBOUNCE_FALL_EN
  logic [WIDTH-1:0]         fall_next;
`endif

  // Per-bit stability filter. The decision uses pre-edge s2 and cnt, so a
  // reversal at the threshold edge cannot be missed. cnt never passes CNT_MAX.
  always_comb begin : filter
    cnt_next   = cnt;
    level_next = level;
    rise_next  = '0;
`ifdef UI_DEBOUNCE_FALL_EN
    fall_next  = '0;
`endif
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (s2[i] == level[i]) begin
        cnt_next[i] = '0;
      end else if (cnt[i] == CNT_MAX) begin
        cnt_next[i]   = '0;
        level_next[i] = s2[i];
        rise_next[i]  = s2[i];
`ifdef UI_DEBOUNCE_FALL_EN
        fall_next[i]  = ~s2[i];
`endif
      end else begin
        cnt_next[i] = cnt[i] + CW'(1);
      end
    end
  end

  // Synchroniser, counters, level and pulse registers.
  always_ff @(posedge clk or negedge rst_n) begin : regs
    if (!rst_n) begin
      s1    <= '0;
      s2    <= '0;
      cnt   <= '0;
      level <= '0;
      rise  <= '0;
`ifdef UI_DEBOUNCE_FALL_EN
      fall  <= '0;
`endif
    end else begin
      s1    <= raw;
      s2    <= s1;
      cnt   <= cnt_next;
      level <= level_next;
      rise  <= rise_next;
`ifdef UI_DEBOUNCE_FALL_EN
      fall  <= fall_next;
`endif
    end
  end

endmodule
